// File: rtl/ubus_pkg.sv
// rtl/ubus_pkg.sv - shared UBUS types, constants and burst-size decode
package ubus_pkg;

  localparam int UBUS_ADDR_W = 16;

  typedef enum logic [1:0] {
    SIZE_1 = 2'b00,
    SIZE_2 = 2'b01,
    SIZE_4 = 2'b10,
    SIZE_8 = 2'b11
  } ubus_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } slave_state_e;

  function automatic logic [3:0] size_to_beats(input ubus_size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ubus_slave_ram.sv
// rtl/ubus_slave_ram.sv - byte-wide slave RAM, one write port, asynchronous read
module ubus_slave_ram
  import ubus_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/ubus_slave_memory.sv
// rtl/ubus_slave_memory.sv - UBUS byte-wide slave serving bursts from an internal RAM window
module ubus_slave_memory
  import ubus_pkg::*;
#(
  parameter logic [UBUS_ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned            DEPTH       = 256,
  parameter int unsigned            WAIT_CYCLES = 0
) (
  input  logic                   ubus_clock,
  input  logic                   ubus_reset,
  input  logic                   ubus_start,
  input  logic [UBUS_ADDR_W-1:0] ubus_addr,
  input  logic [1:0]             ubus_size,
  input  logic                   ubus_read,
  input  logic                   ubus_write,
  input  logic                   ubus_bip,
  input  logic [7:0]             ubus_data_in,
  output logic [7:0]             ubus_data_out,
  output logic                   ubus_data_oe,
  output logic                   ubus_wait,
  output logic                   ubus_error,
  output logic                   prot_err
);

  localparam int unsigned RAM_AW      = $clog2(DEPTH);
  localparam logic [2:0]  WAIT_RELOAD = 3'(WAIT_CYCLES);
  localparam logic [16:0] WIN_LO      = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI      = WIN_LO + 17'(DEPTH) - 17'd1;

  slave_state_e           state_q, state_d;
  logic [UBUS_ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]             beats_q, beats_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   dir_rd_q, dir_rd_d;
  logic [2:0]             wcnt_q, wcnt_d;

  logic [16:0]       first_a, last_a;
  logic              in_range, last_beat, beat_done, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_rdata;

  // 17-bit arithmetic so a burst crossing 16'hFFFF cannot wrap back into the window
  assign first_a   = {1'b0, ubus_addr};
  assign last_a    = first_a + 17'(size_to_beats(ubus_size_e'(ubus_size))) - 17'd1;
  assign in_range  = (first_a >= WIN_LO) && (last_a <= WIN_HI);
  assign last_beat = (cnt_q + 4'd1) == beats_q;
  assign beat_done = (state_q == DATA) && (wcnt_q == 3'd0);
  assign ram_addr  = RAM_AW'(addr_q - BASE_ADDR);
  assign ram_we    = beat_done && !dir_rd_q && !ubus_reset;

  assign ubus_wait     = (state_q == DATA) && (wcnt_q != 3'd0);
  assign ubus_error    = (state_q == ERR);
  assign ubus_data_oe  = (state_q == DATA) && dir_rd_q;
  assign ubus_data_out = ubus_data_oe ? ram_rdata : 8'h00;
  // bip must be low exactly on the final beat; any other pairing is a protocol slip
  assign prot_err      = beat_done && (ubus_bip == last_beat);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    cnt_d    = cnt_q;
    dir_rd_d = dir_rd_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: if (ubus_start) state_d = ADDR;
      ADDR: begin
        addr_d   = ubus_addr;
        beats_d  = size_to_beats(ubus_size_e'(ubus_size));
        cnt_d    = 4'd0;
        dir_rd_d = ubus_read;
        wcnt_d   = WAIT_RELOAD;
        if (!ubus_read && !ubus_write)     state_d = IDLE;
        else if (ubus_read && ubus_write)  state_d = ERR;
        else if (in_range)                 state_d = DATA;
        else                               state_d = ERR;
      end
      DATA: begin
        if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else begin
          addr_d  = addr_q + 16'd1;
          cnt_d   = cnt_q + 4'd1;
          wcnt_d  = WAIT_RELOAD;
          state_d = (ubus_bip && !last_beat) ? DATA : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ubus_clock) begin
    if (ubus_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      beats_q  <= 4'd0;
      cnt_q    <= 4'd0;
      dir_rd_q <= 1'b0;
      wcnt_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      cnt_q    <= cnt_d;
      dir_rd_q <= dir_rd_d;
      wcnt_q   <= wcnt_d;
    end
  end

  ubus_slave_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk_i   (ubus_clock),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ubus_data_in),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_ubus_slave_memory.sv
// tb/tb_ubus_slave_memory.sv - self-checking bench for ubus_slave_memory with two wait settings
module tb_ubus_slave_memory;

  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, rd = 1'b0, wr = 1'b0, bip = 1'b0;
  logic [15:0] addr = '0;
  logic [1:0]  size = '0;
  logic [7:0]  din = '0;
  int          sel = 0;

  logic       start_a, start_b;
  logic [7:0] dout_a, dout_b;
  logic       oe_a, oe_b, wait_a, wait_b, err_a, err_b, prot_a, prot_b;
  logic [7:0] o_dout;
  logic       o_oe, o_wait, o_err, o_prot;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign o_dout  = (sel == 1) ? dout_b : dout_a;
  assign o_oe    = (sel == 1) ? oe_b   : oe_a;
  assign o_wait  = (sel == 1) ? wait_b : wait_a;
  assign o_err   = (sel == 1) ? err_b  : err_a;
  assign o_prot  = (sel == 1) ? prot_b : prot_a;

  ubus_slave_memory #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_a (
    .ubus_clock(clk), .ubus_reset(rst), .ubus_start(start_a), .ubus_addr(addr),
    .ubus_size(size), .ubus_read(rd), .ubus_write(wr), .ubus_bip(bip),
    .ubus_data_in(din), .ubus_data_out(dout_a), .ubus_data_oe(oe_a),
    .ubus_wait(wait_a), .ubus_error(err_a), .prot_err(prot_a)
  );

  ubus_slave_memory #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_b (
    .ubus_clock(clk), .ubus_reset(rst), .ubus_start(start_b), .ubus_addr(addr),
    .ubus_size(size), .ubus_read(rd), .ubus_write(wr), .ubus_bip(bip),
    .ubus_data_in(din), .ubus_data_out(dout_b), .ubus_data_oe(oe_b),
    .ubus_wait(wait_b), .ubus_error(err_b), .prot_err(prot_b)
  );

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] ref_mem [2][DEPTH];

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed {wait,err,oe,prot,data}=%03h expected=%03h", tag, obs, exp);
      $error("check %s mismatch", tag);
    end
  endtask

  task automatic cyc(input string tag, input logic w, input logic e, input logic oe,
                     input logic pe, input logic [7:0] d);
    @(negedge clk);
    check(tag, {o_wait, o_err, o_oe, o_prot, o_dout}, {w, e, oe, pe, d});
    @(posedge clk);
    #1;
  endtask

  // fixed < 0 picks random write data, otherwise beat b writes fixed+b-1.
  // drop is the beat on which bip goes low; drop > beats keeps bip high throughout.
  task automatic xfer(input int inst, input logic [15:0] a, input logic [1:0] sz,
                      input logic r, input logic w, input int drop, input int fixed,
                      input string tag);
    int beats, nb, wc, ai, off;
    bit ok;
    logic [7:0] d, rexp;
    beats = 1 << sz;
    wc    = (inst == 1) ? 2 : 0;
    ai    = int'(a);
    ok    = (r != w) && (ai >= int'(BASE)) && (ai + beats - 1 <= int'(BASE) + DEPTH - 1);
    sel   = inst;
    start = 1'b1;
    cyc({tag, "_start"}, 0, 0, 0, 0, 8'h00);
    start = 1'b0; addr = a; size = sz; rd = r; wr = w;
    cyc({tag, "_addr"}, 0, 0, 0, 0, 8'h00);
    rd = 1'b0; wr = 1'b0;
    if (!r && !w) begin
      cyc({tag, "_noop"}, 0, 0, 0, 0, 8'h00);
    end else if (!ok) begin
      cyc({tag, "_err"}, 0, 1, 0, 0, 8'h00);
    end else begin
      nb = (drop < beats) ? drop : beats;
      for (int b = 1; b <= nb; b++) begin
        off  = ai - int'(BASE) + b - 1;
        d    = (fixed < 0) ? 8'($urandom) : 8'(fixed + b - 1);
        rexp = r ? ref_mem[inst][off] : 8'h00;
        din  = d;
        bip  = (b != drop);
        for (int k = 0; k < wc; k++) cyc({tag, "_wait"}, 1, 0, r, 0, rexp);
        cyc({tag, "_beat"}, 0, 0, r, (b == nb) && (drop != beats), rexp);
        if (w) ref_mem[inst][off] = d;
      end
      bip = 1'b0;
    end
    cyc({tag, "_idle"}, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    int rsel, dsel, sz, lo;
    logic [7:0] d1;

    @(posedge clk); #1;
    sel = 0; cyc("reset_a", 0, 0, 0, 0, 8'h00);
    sel = 1; cyc("reset_b", 0, 0, 0, 0, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH / 8; j++)
        xfer(i, BASE + 16'(8 * j), 2'b11, 0, 1, 8, -1, "fill");

    xfer(0, 16'h0100, 2'b00, 0, 1, 1, 8'hA5, "wr1");
    xfer(0, 16'h0100, 2'b00, 1, 0, 1, -1, "rd1");
    xfer(0, 16'h0108, 2'b11, 0, 1, 8, 8'h10, "wr8");
    xfer(0, 16'h0108, 2'b11, 1, 0, 8, -1, "rd8");

    xfer(1, 16'h0120, 2'b10, 1, 0, 4, -1, "rd4_wait");
    xfer(1, 16'h0130, 2'b01, 0, 1, 2, -1, "wr2_wait");
    xfer(1, 16'h0130, 2'b01, 1, 0, 2, -1, "rd2_wait");

    xfer(0, 16'h01FE, 2'b10, 0, 1, 4, -1, "overrun");
    xfer(0, 16'h01FC, 2'b10, 1, 0, 4, -1, "overrun_chk");
    xfer(0, 16'h00FF, 2'b00, 1, 0, 1, -1, "below_base");
    xfer(0, 16'h0110, 2'b00, 1, 1, 1, -1, "rdwr");
    xfer(0, 16'h0110, 2'b00, 0, 0, 1, -1, "noop");

    xfer(0, 16'h0140, 2'b10, 0, 1, 2, 8'hC0, "early_bip");
    xfer(0, 16'h0140, 2'b10, 1, 0, 4, -1, "early_bip_chk");
    xfer(1, 16'h0150, 2'b01, 0, 1, 9, -1, "late_bip");
    xfer(1, 16'h0150, 2'b01, 1, 0, 2, -1, "late_bip_chk");

    // reset lands in the first wait cycle of beat 2 of a 4-beat write
    sel = 1; start = 1'b1;
    cyc("mid_rst_start", 0, 0, 0, 0, 8'h00);
    start = 1'b0; addr = 16'h0180; size = 2'b10; wr = 1'b1;
    cyc("mid_rst_addr", 0, 0, 0, 0, 8'h00);
    wr = 1'b0; bip = 1'b1; d1 = 8'($urandom); din = d1;
    cyc("mid_rst_w0", 1, 0, 0, 0, 8'h00);
    cyc("mid_rst_w1", 1, 0, 0, 0, 8'h00);
    cyc("mid_rst_b1", 0, 0, 0, 0, 8'h00);
    ref_mem[1][8'h80] = d1;
    din = ~d1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bip = 1'b0;
    cyc("mid_rst_after", 0, 0, 0, 0, 8'h00);
    cyc("mid_rst_idle", 0, 0, 0, 0, 8'h00);
    xfer(1, 16'h0180, 2'b10, 1, 0, 4, -1, "mid_rst_chk");

    for (int n = 0; n < 40; n++) begin
      rsel = $urandom_range(0, 9);
      dsel = $urandom_range(0, 5);
      sz   = $urandom_range(0, 3);
      lo   = $urandom_range(16'h00F0, 16'h0208);
      xfer($urandom_range(0, 1), 16'(lo), 2'(sz),
           (rsel == 0) || (rsel >= 2 && rsel <= 5),
           (rsel == 0) || (rsel >= 6),
           (dsel == 0) ? $urandom_range(1, 9) : (1 << sz), -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
